// File: rtl/count_disp_pkg.sv
// rtl/count_disp_pkg.sv - shared constants for the count/wrap 7-segment display path
//
// Purpose: segment patterns for hex digits, the blank pattern and the digit
// index values shared by the display stage and its decoder.
// Ports: none (package).

package count_disp_pkg;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Value of the digit-select bit for each digit position.
    localparam logic DIG_CNT  = 1'b0;
    localparam logic DIG_WRAP = 1'b1;

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational 4-bit to 7-segment decoder
//
// Purpose: maps a hex nibble onto its segment pattern.
// Ports:
//   val - 4-bit value to display
//   seg - segment drive {g,f,e,d,c,b,a}, active-high

module hex7seg
    import count_disp_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[val];

endmodule

// File: rtl/count_scan_display.sv
// rtl/count_scan_display.sv - 2-digit multiplexed display of live count and wrap tally
//
// Purpose: registers the upstream counter value, counts 15->0 wraps mod 16,
// and alternates the two digits on the display every SCAN_DIV cycles.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset (0 = reset)
//   q_in     - 4-bit counter value from the upstream up-counter
//   seg      - registered segment drive {g,f,e,d,c,b,a}, active-high
//   an       - registered one-hot digit enables; an[0] count, an[1] wrap tally
//   wrap_cnt - number of wraps observed, mod 16

module count_scan_display
    import count_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] q_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] wrap_cnt
);

    localparam int CNT_W = $clog2(SCAN_DIV + 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    logic [3:0]       q_s_q, q_s_d;
    logic [3:0]       wrap_cnt_q, wrap_cnt_d;
    logic [CNT_W-1:0] scan_q, scan_d;
    logic             sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;

    logic [3:0]       digit_val;
    logic [6:0]       digit_seg;

    hex7seg u_hex7seg (
        .val (digit_val),
        .seg (digit_seg)
    );

    always_comb begin
        q_s_d      = q_in;
        wrap_cnt_d = wrap_cnt_q;
        scan_d     = scan_q + CNT_W'(1);
        sel_d      = sel_q;

        // Only a genuine F->0 step is a wrap; since q_s resets to 0 the
        // first sample after reset can never look like one.
        if (q_s_q == 4'hF && q_in == 4'h0) begin
            wrap_cnt_d = wrap_cnt_q + 4'd1;
        end

        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            sel_d  = ~sel_q;
        end

        // The output register shows the values held this cycle, so a new
        // sample or wrap appears on the display one edge later.
        digit_val = (sel_q == DIG_WRAP) ? wrap_cnt_q : q_s_q;
        an_d      = (sel_q == DIG_CNT) ? 2'b01 : 2'b10;
        seg_d     = digit_seg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_s_q      <= 4'h0;
            wrap_cnt_q <= 4'h0;
            scan_q     <= '0;
            sel_q      <= DIG_CNT;
            seg_q      <= SEG_BLANK;
            an_q       <= 2'b00;
        end else begin
            q_s_q      <= q_s_d;
            wrap_cnt_q <= wrap_cnt_d;
            scan_q     <= scan_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_count_scan_display.sv
// tb/tb_count_scan_display.sv - scoreboard bench for count_scan_display

module tb_count_scan_display;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       reset;
    logic [3:0] q_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] wrap_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] seg;
        logic [1:0] an;
        logic [3:0] wc;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] font [16];

    // reference state
    int m_edges;
    int m_prev;
    int m_wraps;

    logic [3:0] last_drv;

    count_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .q_in     (q_in),
        .seg      (seg),
        .an       (an),
        .wrap_cnt (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        font[0]  = 7'h3F; font[1]  = 7'h06; font[2]  = 7'h5B; font[3]  = 7'h4F;
        font[4]  = 7'h66; font[5]  = 7'h6D; font[6]  = 7'h7D; font[7]  = 7'h07;
        font[8]  = 7'h7F; font[9]  = 7'h6F; font[10] = 7'h77; font[11] = 7'h7C;
        font[12] = 7'h39; font[13] = 7'h5E; font[14] = 7'h79; font[15] = 7'h71;
    end

    // Reference model: the digit shown at an edge depends only on how many
    // edges have passed since reset, the count digit is the previous sample,
    // and the tally counts F->0 steps in the sampled sequence.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_edges = 0;
            m_prev  = 0;
            m_wraps = 0;
            exp_q.delete();
        end else begin
            exp_t e;
            int wrap_digit;
            wrap_digit = (m_edges / SCAN_DIV) % 2;
            if (wrap_digit == 1) begin
                e.an  = 2'b10;
                e.seg = font[m_wraps % 16];
            end else begin
                e.an  = 2'b01;
                e.seg = font[m_prev];
            end
            if (m_prev == 15 && int'(q_in) == 0) m_wraps = m_wraps + 1;
            m_prev  = int'(q_in);
            m_edges = m_edges + 1;
            e.wc    = 4'(m_wraps % 16);
            exp_q.push_back(e);
        end
    end

    // Monitor: compares each registered output against the queued expectation.
    always @(negedge clk) begin
        if (reset && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (seg !== e.seg || an !== e.an || wrap_cnt !== e.wc) begin
                errors++;
                $display("FAIL scoreboard t=%0t: seg=%h an=%b wrap_cnt=%h, required seg=%h an=%b wrap_cnt=%h",
                         $time, seg, an, wrap_cnt, e.seg, e.an, e.wc);
            end
        end
    end

    task automatic check_blank(input string name);
        checks++;
        if (seg !== 7'h00 || an !== 2'b00 || wrap_cnt !== 4'h0) begin
            errors++;
            $display("FAIL %s: seg=%h an=%b wrap_cnt=%h, required seg=00 an=00 wrap_cnt=0",
                     name, seg, an, wrap_cnt);
        end
    endtask

    // Drive a value for one clock edge; returns at posedge+1.
    task automatic drive(input logic [3:0] v);
        q_in = v;
        last_drv = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        q_in     = 4'h7;
        last_drv = 4'h7;
        #2;
        check_blank("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_blank("reset_held");

        // release away from both edges
        @(negedge clk);
        #1 reset = 1'b1;
        q_in = 4'h5;
        @(posedge clk);
        #1;
        checks++;
        if (an !== 2'b01 || seg !== 7'h3F) begin
            errors++;
            $display("FAIL first_edge: an=%b seg=%h, required an=01 seg=3F", an, seg);
        end

        // constant input for a few scan periods
        repeat (20) drive(4'h2);

        // full counting cycles: 17 wraps take the tally through F back around
        for (int r = 0; r < 17; r++)
            for (int v = 0; v < 16; v++) drive(4'(v));
        drive(4'h0);

        // sequences that must not count as wraps
        drive(4'hF); drive(4'h3); drive(4'h0); drive(4'h0);
        drive(4'hE); drive(4'h0);
        repeat (6) drive(4'h1);

        // randomized: mostly counting, with occasional jumps
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) != 0) drive(last_drv + 4'd1);
            else drive(4'($urandom_range(0, 15)));
        end

        // reset between edges mid-operation
        repeat (3) drive(4'hF);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_blank("reset_mid_run");
        @(posedge clk);
        #1;
        check_blank("reset_mid_held");
        @(negedge clk);
        #1 reset = 1'b1;
        q_in = 4'h0;

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 5) != 0) drive(last_drv + 4'd1);
            else drive(4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
